multi_tone_buzzer: RTL
======================

# multi_tone_buzzer

Parametrised successor to the single-channel buzzer: a memory-mapped square-wave tone generator with `CHANNELS` independent channels. Each channel has:
- a programmable half-period divisor,
- an optional note duration that stops the channel automatically,
- a readable status word.

It sits on the CPU I/O bus as a peripheral, driving per-channel tone outputs and one OR-mixed buzzer pin. Unlike the previous block, deasserting `Select` does not clear state. Only `reset` does.

## Interface
- `CHANNELS`, 2, number of tone channels (1..8).
- `PRESCALE`, 50000, clocks per duration tick (≥2).
- `DUR_WIDTH`, 16, width of duration register/counter (≤16).
- `clock` in 1, system clock; single clock domain.
- `reset` in 1, synchronous, active-high; clears all state on the next rising edge.
- `Write_enable` in 1, bus write strobe; effective only with `Select`=1.
- `Read_enable` in 1, bus read strobe; effective only with `Select`=1.
- `Select` in 1, chip select for this peripheral.
- `Address` in 6, halfword byte address:
  - [0] ignored.
  - [2:1] register.
  - [5:3] channel.
- `Write_data_in` in 16, write data.
- `Read_data_out` out 16, registered read data.
- `Tone_out` out CHANNELS, per-channel square wave.
- `Buzzer_output` out 1, OR of all `Tone_out` bits.

## Operation
- Register map per channel (`Address[2:1]`):
  - 0 PERIOD (16b, R/W).
  - 1 DURATION (`DUR_WIDTH` b, R/W, in ticks; 0 = unlimited).
  - 2 CONTROL (W: bit0 enable; R: bit0 enable).
  - 3 STATUS (R only: bit0 active, bit1 done, bit2 current `Tone_out` level, others 0).
- Channel index ≥`CHANNELS`: writes are ignored, reads return 0.
- Shared prescaler counts 0..`PRESCALE`-1 continuously from reset. It emits a 1-cycle tick when it wraps to 0.
- Per-channel state: `period`, `duration`, `remaining`, `count` (16b), `active`, `done`, `level`.
- Tone generation while `active`=1 and `period`≠0:
  - `count` increments each clock.
  - When `count`==`period`: `level` toggles and `count` returns to 0.
  - Half-period = `period`+1 clocks.
- `period`==0: `level` held 0 and `count` held 0; the channel can still be active and timing duration.
- Write CONTROL bit0=1:
  - `active`←1, `done`←0.
  - `remaining`←`duration`, `count`←0, `level`←0.
  - Applies even if the channel is already active (restart).
- Write CONTROL bit0=0: `active`←0, `level`←0, `count`←0. `done` is unchanged.
- Duration expiry (`duration`≠0): on each tick while active, `remaining` decrements. When a tick finds `remaining`==1:
  - `remaining`←0, `active`←0, `level`←0, `done`←1.
- `duration`==0: `remaining` never decrements; the channel plays until disabled.
- Write PERIOD while active: `period` updated, `count`←0, `level`←0. Playback continues at the new pitch.
- Write DURATION while active: only the register changes. `remaining` is unaffected until the next enable.
- `done` is sticky. It is cleared by reset or by any CONTROL write with bit0=1. A STATUS read does not clear it.
- Simultaneous CONTROL write and expiry tick on the same channel: the write wins. Writes to other registers coincide with expiry normally.
- `Write_enable` and `Read_enable` both high: both are performed; the read returns the pre-write value.

## Timing
- Reset values: every `Tone_out` bit 0, `Buzzer_output` 0, `Read_data_out` 0.
- Reset values of internal state: `period` 0, `duration` 0, `remaining` 0, `count` 0, `active` 0, `done` 0, prescaler 0.
- Writes take effect at the rising edge where `Select`&`Write_enable`.
- Read latency is 1 cycle: `Read_data_out` is valid after the edge where `Select`&`Read_enable`. Otherwise it holds its previous value.
- Enable written at edge E with `period`=P>0: first `Tone_out` rise at edge E+P+1, then toggles every P+1 edges.
- `Tone_out` and `Buzzer_output` are registered. `Buzzer_output` lags `Tone_out` by 0 cycles (combinational OR of registered bits).
- Expiry: `active`, `level` and `done` update on the same edge as the tick that finds `remaining`==1.
- Note length with `duration`=D: D-1 to D tick intervals, since the prescaler phase is not reset by enable.
- Reset mid-note: all channels are silent the edge after reset is sampled high.

## Test plan
- Reset, then channel 0 PERIOD=3, CONTROL=1 → `Tone_out[0]` rises 4 clocks after the write, then toggles every 4 clocks; `Buzzer_output` matches.
- PRESCALE=4, ch1 PERIOD=1, DURATION=3, CONTROL=1 → ch1 stops within 9-12 clocks; STATUS reads 0x0002 one cycle after the read strobe; a second CONTROL=1 clears `done`.
- Both channels active (P=2, P=5), then `Select`=0 for 20 clocks → both continue toggling; `reset`=1 for one cycle → all outputs 0 next edge, all registers read 0.
- Write ch0 PERIOD=7 while it plays P=2 → `level` drops to 0, next rise 8 clocks later; DURATION rewrite mid-note does not change the current expiry.
- CONTROL=1 written on the exact cycle of the expiry tick → channel stays active, `done`=0, `remaining` reloaded.
- Write to channel 5 with CHANNELS=2 → no state changes, read returns 0; PERIOD=0 with enable → `Tone_out` stays 0, STATUS bit0=1.

Source files
------------

// File: rtl/multi_tone_buzzer_if.sv
// multi_tone_buzzer_if: CPU I/O bus connection for the multi-channel tone generator
// master drives Select, Write_enable, Read_enable, Address[5:0] and Write_data_in[15:0];
// the slave (the peripheral) returns the registered Read_data_out[15:0].
interface multi_tone_buzzer_if;
  logic        Write_enable;
  logic        Read_enable;
  logic        Select;
  logic [5:0]  Address;
  logic [15:0] Write_data_in;
  logic [15:0] Read_data_out;
  modport master(output Write_enable, Read_enable, Select, Address, Write_data_in, input Read_data_out);
  modport slave(input Write_enable, Read_enable, Select, Address, Write_data_in, output Read_data_out);
endinterface

// File: rtl/multi_tone_buzzer.sv
// multi_tone_buzzer: memory-mapped square-wave generator with CHANNELS independent tone channels
// clock/reset: single clock, synchronous active-high reset
// bus: slave side of the CPU I/O bus (Address[2:1] register, Address[5:3] channel)
// Tone_out: per-channel registered square waves; Buzzer_output: OR of all Tone_out bits
module multi_tone_buzzer #(
  parameter int CHANNELS  = 2,
  parameter int PRESCALE  = 50000,
  parameter int DUR_WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  multi_tone_buzzer_if.slave  bus,
  output logic [CHANNELS-1:0] Tone_out,
  output logic                Buzzer_output
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0]        pre;
  logic                 tick;
  logic [15:0]          period    [CHANNELS];
  logic [DUR_WIDTH-1:0] duration  [CHANNELS];
  logic [DUR_WIDTH-1:0] remaining [CHANNELS];
  logic [15:0]          count     [CHANNELS];
  logic [CHANNELS-1:0]  active, done, level;
  logic                 wr, rd;
  logic [2:0]           ch;
  logic [1:0]           sel;
  logic [15:0]          rdata;
  assign wr            = bus.Select & bus.Write_enable;
  assign rd            = bus.Select & bus.Read_enable;
  assign ch            = bus.Address[5:3];
  assign sel           = bus.Address[2:1];
  assign tick          = pre == PW'(PRESCALE - 1);
  assign Tone_out      = level;
  assign Buzzer_output = |level;
  always_ff @(posedge clock) begin
    if (reset) pre <= '0;
    else       pre <= tick ? '0 : pre + PW'(1);
  end
  // Bus writes are applied last so a CONTROL write beats a coincident expiry tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        period[i]    <= '0;
        duration[i]  <= '0;
        remaining[i] <= '0;
        count[i]     <= '0;
      end
      active <= '0;
      done   <= '0;
      level  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (active[i] && period[i] != 16'd0) begin
          count[i] <= count[i] == period[i] ? 16'd0 : count[i] + 16'd1;
          if (count[i] == period[i]) level[i] <= ~level[i];
        end
        // remaining is 0 for an unlimited note, so it never counts down
        if (active[i] && tick && remaining[i] != '0) begin
          remaining[i] <= remaining[i] - DUR_WIDTH'(1);
          if (remaining[i] == DUR_WIDTH'(1)) begin
            active[i] <= 1'b0;
            level[i]  <= 1'b0;
            done[i]   <= 1'b1;
          end
        end
        if (wr && ch == 3'(i)) begin
          if (sel == 2'd0) begin
            period[i] <= bus.Write_data_in;
            count[i]  <= '0;
            level[i]  <= 1'b0;
          end
          if (sel == 2'd1) duration[i] <= bus.Write_data_in[DUR_WIDTH-1:0];
          if (sel == 2'd2) begin
            active[i] <= bus.Write_data_in[0];
            count[i]  <= '0;
            level[i]  <= 1'b0;
            if (bus.Write_data_in[0]) begin
              done[i]      <= 1'b0;
              remaining[i] <= duration[i];
            end
          end
        end
      end
    end
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch == 3'(i))
        rdata = sel == 2'd0 ? period[i] :
                sel == 2'd1 ? 16'(duration[i]) :
                sel == 2'd2 ? {15'd0, active[i]} :
                              {13'd0, level[i], done[i], active[i]};
  end
  always_ff @(posedge clock) begin
    if (reset)   bus.Read_data_out <= '0;
    else if (rd) bus.Read_data_out <= rdata;
  end
endmodule
